// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
// Raster timing bus carried from the timing generator to the drawing stages.
//   hcount      [11:0]  current pixel within the line
//   vcount      [11:0]  current line within the frame
//   hsync               horizontal sync (polarity set by the generator)
//   vsync               vertical sync (polarity set by the generator)
//   hblnk               high while hcount is outside the visible area
//   vblnk               high while vcount is outside the visible area
//   frame_start         one-cycle pulse when the raster wraps to (0,0)
// Modports: master drives the bus (timing generator), slave consumes it.
// -----------------------------------------------------------------------------
interface vga_timing_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;

  modport master (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
  );

  modport slave (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
// Free-running VGA raster timing generator (default 800x600 @ 60 Hz, 40 MHz).
// Ports:
//   pclk   in   pixel clock, rising edge
//   rst    in   asynchronous, active-low reset
//   vga    master modport of vga_timing_if: hcount, vcount, hsync, vsync,
//          hblnk, vblnk, frame_start (all registered, mutually aligned)
// Sync, blank and frame_start are decoded from the next-count values and
// registered alongside the counts, so every output describes the same pixel.
// -----------------------------------------------------------------------------
module vga_timing #(
  parameter int H_ACTIVE  = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_ACTIVE  = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic         pclk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS      = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS      = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [11:0] hcount_reg, hcount_next;
  logic [11:0] vcount_reg, vcount_next;
  logic        hsync_reg, hsync_next;
  logic        vsync_reg, vsync_next;
  logic        hblnk_reg, hblnk_next;
  logic        vblnk_reg, vblnk_next;
  logic        frame_start_reg, frame_start_next;
  logic        h_wrap, v_wrap;

  always_comb begin
    h_wrap = (hcount_reg == H_LAST);
    v_wrap = (vcount_reg == V_LAST);

    hcount_next = h_wrap ? 12'd0 : hcount_reg + 12'd1;

    // vcount only moves on the line wrap, which keeps vsync/vblnk
    // line-granular without any extra gating.
    vcount_next = vcount_reg;
    if (h_wrap) begin
      vcount_next = v_wrap ? 12'd0 : vcount_reg + 12'd1;
    end

    hblnk_next = (hcount_next >= H_VIS);
    vblnk_next = (vcount_next >= V_VIS);
    hsync_next = ((hcount_next >= HS_START) && (hcount_next < HS_END))
                 ? HSYNC_POL : !HSYNC_POL;
    vsync_next = ((vcount_next >= VS_START) && (vcount_next < VS_END))
                 ? VSYNC_POL : !VSYNC_POL;

    // Only a genuine wrap into (0,0) pulses; the post-reset (0,0) does not.
    frame_start_next = h_wrap && v_wrap;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_reg      <= 12'd0;
      vcount_reg      <= 12'd0;
      hsync_reg       <= !HSYNC_POL;
      vsync_reg       <= !VSYNC_POL;
      hblnk_reg       <= 1'b0;
      vblnk_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      hcount_reg      <= hcount_next;
      vcount_reg      <= vcount_next;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      hblnk_reg       <= hblnk_next;
      vblnk_reg       <= vblnk_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign vga.hcount      = hcount_reg;
  assign vga.vcount      = vcount_reg;
  assign vga.hsync       = hsync_reg;
  assign vga.vsync       = vsync_reg;
  assign vga.hblnk       = hblnk_reg;
  assign vga.vblnk       = vblnk_reg;
  assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
// Drives two generators from one clock and reset: the default 800x600 timing
// (active-high syncs) and a small raster with active-low syncs so that whole
// frames fit in a short run. Every cycle each output bus is compared with a
// reference computed from the raster position (edges since reset release).
// -----------------------------------------------------------------------------
module tb_vga_timing;

  // Small raster: H_TOTAL = 28, V_TOTAL = 16, frame = 448 cycles.
  localparam int S_HA = 16, S_HF = 3, S_HS = 5, S_HB = 4;
  localparam int S_VA = 10, S_VF = 1, S_VS = 2, S_VB = 3;
  localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

  logic pclk;
  logic rst;

  vga_timing_if if_def ();
  vga_timing_if if_sml ();

  vga_timing dut_def (
    .pclk (pclk),
    .rst  (rst),
    .vga  (if_def)
  );

  vga_timing #(
    .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
  ) dut_sml (
    .pclk (pclk),
    .rst  (rst),
    .vga  (if_sml)
  );

  int n_vec;
  int n_err;
  int t;        // rising edges since reset release
  bit in_rst;
  int fs_cnt;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check_eq(input string tag, input logic [28:0] obs, input logic [28:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%h expected=%h", tag, t, obs, exp);
    end
  endtask

  // Packing: {hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start}
  function automatic logic [28:0] model(input int tt, input bit rs,
                                        input int ha, input int hf, input int hs, input int hb,
                                        input int va, input int vf, input int vs, input int vb,
                                        input bit hp, input bit vp);
    int ht, vt, pos, hc, vc;
    logic hsy, vsy;
    if (rs) return {24'd0, ~hp, ~vp, 3'b000};
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    pos = tt % (ht * vt);
    hc  = pos % ht;
    vc  = pos / ht;
    hsy = (hc >= ha + hf && hc < ha + hf + hs) ? hp : ~hp;
    vsy = (vc >= va + vf && vc < va + vf + vs) ? vp : ~vp;
    return {12'(hc), 12'(vc), hsy, vsy, (hc >= ha), (vc >= va), (tt > 0 && pos == 0)};
  endfunction

  task automatic check_all();
    check_eq("def_bus",
             {if_def.hcount, if_def.vcount, if_def.hsync, if_def.vsync,
              if_def.hblnk, if_def.vblnk, if_def.frame_start},
             model(t, in_rst, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1));
    check_eq("sml_bus",
             {if_sml.hcount, if_sml.vcount, if_sml.hsync, if_sml.vsync,
              if_sml.hblnk, if_sml.vblnk, if_sml.frame_start},
             model(t, in_rst, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, 1'b0));
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
    t++;
    check_all();
    if (if_sml.frame_start) fs_cnt++;
  endtask

  initial begin
    int n;
    int k;
    n_vec  = 0;
    n_err  = 0;
    t      = 0;
    fs_cnt = 0;
    in_rst = 1'b1;
    rst    = 1'b1;
    #1 rst = 1'b0;             // asserted between edges, before any clock
    #1 check_all();
    repeat (10) begin
      @(posedge pclk);
      #1 check_all();
    end
    @(negedge pclk);
    rst    = 1'b1;
    in_rst = 1'b0;
    t      = 0;

    // Long run: three default lines, several small frames.
    repeat (3 * 1056 + 200) step();
    check_eq("fs_count", 29'(fs_cnt), 29'((3 * 1056 + 200) / S_FRAME));

    // Random mid-frame resets, asserted between edges.
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(20, 1200);
      repeat (n) step();
      #2;
      rst    = 1'b0;
      in_rst = 1'b1;
      #1 check_all();          // cleared without a clock edge
      k = $urandom_range(1, 4);
      repeat (k) begin
        @(posedge pclk);
        #1 check_all();
      end
      @(negedge pclk);
      rst    = 1'b1;
      in_rst = 1'b0;
      t      = 0;
    end

    // Post-release: full small frame, no pulse until the real wrap.
    fs_cnt = 0;
    repeat (S_FRAME + 5) step();
    check_eq("fs_after_rel", 29'(fs_cnt), 29'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
